// File: rtl/cmp_seq16.sv
// cmp_seq16: nibble-serial magnitude comparator with big/equal/small cascade and start/done handshake
module cmp_seq16 #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             fi_big,
  input  logic             fi_equal,
  input  logic             fi_small,
  output logic             busy,
  output logic             done,
  output logic             fo_big,
  output logic             fo_equal,
  output logic             fo_small
);
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0] k_q, k_d;
  logic [2:0] fo_q, fo_d;
  logic [DIGIT-1:0] sa, sb;
  logic fi_unused;
  assign fi_unused = fi_equal;
  assign sa = a_q[WIDTH-1 -: DIGIT];
  assign sb = b_q[WIDTH-1 -: DIGIT];
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    k_d = k_q;
    fo_d = fo_q;
    unique case (state_q)
      IDLE: if (start) begin
        a_d = a;
        b_d = b;
        k_d = KW'(NSLICE - 1);
        state_d = (fi_big | fi_small) ? FIN : CMP;
        fo_d = fi_big ? 3'b100 : fi_small ? 3'b001 : fo_q;
      end
      CMP: if (sa != sb) begin
        state_d = FIN;
        fo_d = sa > sb ? 3'b100 : 3'b001;
      end else if (k_q == '0) begin
        state_d = FIN;
        fo_d = 3'b010;
      end else begin
        k_d = k_q - KW'(1);
        a_d = a_q << DIGIT;
        b_d = b_q << DIGIT;
      end
      FIN: begin
        state_d = IDLE;
        k_d = KW'(NSLICE - 1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      k_q <= KW'(NSLICE - 1);
      fo_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      k_q <= k_d;
      fo_q <= fo_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign {fo_big, fo_equal, fo_small} = fo_q;
endmodule
